// File: rtl/parking_pkg.sv
// ----------------------------------------------------------------------------
// parking_pkg
// Shared types and constants for the parking gate controller.
//   gate_state_t          : barrier FSM state encoding
//   DEF_CAPACITY          : default number of parking spaces
//   DEF_GATE_OPEN_CYCLES  : default barrier open time in clock cycles
//   TIMER_W               : width of the barrier open-time down-counter
// ----------------------------------------------------------------------------
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2
    } gate_state_t;

    localparam int DEF_CAPACITY         = 8;
    localparam int DEF_GATE_OPEN_CYCLES = 16;
    localparam int TIMER_W              = 16;

endpackage : parking_pkg

// File: rtl/edge_detect.sv
// ----------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a debounced button level.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   in    in  debounced button level
//   rise  out high while in is 1 and the registered copy is still 0
// The registered copy resets to 1 so a button held through reset release
// does not produce an event until it has dropped and risen again.
// ----------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rise
);

    logic r_prev;

    // Registered copy of the input level, held at 1 during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= in;
        end
    end

    assign rise = in & ~r_prev;

endmodule : edge_detect

// File: rtl/parking_gate_ctrl.sv
// ----------------------------------------------------------------------------
// parking_gate_ctrl
// Barrier controller: detects entry/exit button edges, tracks lot occupancy,
// opens the barrier for GATE_OPEN_CYCLES per admitted or departing car and
// pulses rejectPulse when an entry is refused because the lot is full.
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   entryBtn     in  debounced entry request level
//   exitBtn      in  debounced exit request level
//   gateOpen     out registered barrier open command
//   occupancy    out cars currently inside (CNT_W bits)
//   full         out occupancy == CAPACITY
//   empty        out occupancy == 0
//   rejectPulse  out registered one-cycle pulse for a refused entry
// ----------------------------------------------------------------------------
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY         = DEF_CAPACITY,
    parameter int GATE_OPEN_CYCLES = DEF_GATE_OPEN_CYCLES,
    parameter int CNT_W            = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entryBtn,
    input  logic             exitBtn,
    output logic             gateOpen,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             rejectPulse
);

    localparam logic [CNT_W-1:0]   CAP_C        = CNT_W'(CAPACITY);
    localparam logic [TIMER_W-1:0] TIMER_LOAD_C = TIMER_W'(GATE_OPEN_CYCLES - 1);

    gate_state_t        r_state;
    gate_state_t        w_next_state;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_d;
    logic [CNT_W-1:0]   r_occ;
    logic [CNT_W-1:0]   w_occ_d;
    logic               r_gate;
    logic               w_gate_d;
    logic               r_reject;
    logic               w_reject_d;

    logic w_entry_rise;
    logic w_exit_rise;
    logic w_full;
    logic w_empty;
    logic w_exit_ok;
    logic w_entry_ok;
    logic w_entry_rej;
    logic w_timer_done;

    edge_detect u_entry_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (entryBtn),
        .rise (w_entry_rise)
    );

    edge_detect u_exit_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (exitBtn),
        .rise (w_exit_rise)
    );

    assign w_full       = (r_occ == CAP_C);
    assign w_empty      = (r_occ == {CNT_W{1'b0}});
    assign w_timer_done = (r_timer == {TIMER_W{1'b0}});

    // Exit has priority; an entry coinciding with a valid exit is dropped
    // without a reject.
    assign w_exit_ok   = w_exit_rise & ~w_empty;
    assign w_entry_ok  = w_entry_rise & ~w_full & ~w_exit_ok;
    assign w_entry_rej = w_entry_rise & w_full & ~w_exit_ok;

    // State, timer, occupancy and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_timer  <= {TIMER_W{1'b0}};
            r_occ    <= {CNT_W{1'b0}};
            r_gate   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_timer  <= w_timer_d;
            r_occ    <= w_occ_d;
            r_gate   <= w_gate_d;
            r_reject <= w_reject_d;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_exit_ok) begin
                    w_next_state = OPEN_OUT;
                end else if (w_entry_ok) begin
                    w_next_state = OPEN_IN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (w_timer_done) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output, timer and occupancy next values
    always_comb begin
        w_timer_d  = r_timer;
        w_occ_d    = r_occ;
        w_reject_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_exit_ok) begin
                    w_timer_d = TIMER_LOAD_C;
                    w_occ_d   = r_occ - CNT_W'(1);
                end else if (w_entry_ok) begin
                    w_timer_d = TIMER_LOAD_C;
                    w_occ_d   = r_occ + CNT_W'(1);
                end else if (w_entry_rej) begin
                    w_reject_d = 1'b1;
                end else begin
                    w_timer_d = r_timer;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (!w_timer_done) begin
                    w_timer_d = r_timer - TIMER_W'(1);
                end else begin
                    w_timer_d = r_timer;
                end
            end
            default: begin
                w_timer_d = {TIMER_W{1'b0}};
            end
        endcase

        // Gate register tracks the upcoming state so it opens on the same
        // edge the FSM leaves IDLE and closes on the edge it returns.
        if (w_next_state != IDLE) begin
            w_gate_d = 1'b1;
        end else begin
            w_gate_d = 1'b0;
        end
    end

    assign gateOpen    = r_gate;
    assign occupancy   = r_occ;
    assign full        = w_full;
    assign empty       = w_empty;
    assign rejectPulse = r_reject;

endmodule : parking_gate_ctrl

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;

    localparam int CAP   = 8;
    localparam int OPEN  = 16;
    localparam int CW    = $clog2(CAP + 1);

    logic          clk;
    logic          rst_n;
    logic          entryBtn;
    logic          exitBtn;
    logic          gateOpen;
    logic [CW-1:0] occupancy;
    logic          full;
    logic          empty;
    logic          rejectPulse;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       is_reject;
        logic [7:0] occ;
    } exp_t;

    exp_t exp_q[$];

    parking_gate_ctrl #(
        .CAPACITY        (CAP),
        .GATE_OPEN_CYCLES(OPEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .entryBtn   (entryBtn),
        .exitBtn    (exitBtn),
        .gateOpen   (gateOpen),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty),
        .rejectPulse(rejectPulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic press(input bit ent, input bit ext, input int hold);
        @(posedge clk);
        #1;
        if (ent) entryBtn = 1'b1;
        if (ext) exitBtn = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        entryBtn = 1'b0;
        exitBtn  = 1'b0;
    endtask

    task automatic expect_gate(input int occ_after);
        exp_t e;
        e.is_reject = 1'b0;
        e.occ       = 8'(occ_after);
        exp_q.push_back(e);
    endtask

    task automatic expect_reject(input int occ_now);
        exp_t e;
        e.is_reject = 1'b1;
        e.occ       = 8'(occ_now);
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT raises gateOpen or rejectPulse
    initial begin : monitor
        logic prev_gate;
        logic prev_rej;
        int   hi_len;
        exp_t e;
        prev_gate = 1'b0;
        prev_rej  = 1'b0;
        hi_len    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_gate = 1'b0;
                prev_rej  = 1'b0;
                hi_len    = 0;
            end else begin
                if (gateOpen && !prev_gate) begin
                    vectors++;
                    hi_len = 1;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL gate_unexpected: gateOpen rose with occupancy=%0d, expected no gate", occupancy);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_reject || int'(occupancy) != int'(e.occ)) begin
                            miscompares++;
                            $display("FAIL gate_event: got gate with occupancy=%0d, expected reject=%0b occupancy=%0d",
                                     occupancy, e.is_reject, e.occ);
                        end
                    end
                end else if (gateOpen) begin
                    hi_len++;
                end
                if (!gateOpen && prev_gate) begin
                    chk("gate_len", hi_len, OPEN);
                end
                if (rejectPulse && !prev_rej) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL reject_unexpected: rejectPulse with occupancy=%0d, expected none", occupancy);
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_reject || gateOpen || int'(occupancy) != int'(e.occ)) begin
                            miscompares++;
                            $display("FAIL reject_event: got reject gate=%0b occupancy=%0d, expected reject=%0b gate=0 occupancy=%0d",
                                     gateOpen, occupancy, e.is_reject, e.occ);
                        end
                    end
                end
                if (prev_rej) begin
                    chk("reject_len", int'(rejectPulse), 0);
                end
                prev_gate = gateOpen;
                prev_rej  = rejectPulse;
            end
        end
    end

    // Directed stimulus
    initial begin : stimulus
        rst_n    = 1'b0;
        entryBtn = 1'b0;
        exitBtn  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gate", int'(gateOpen), 0);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_reject", int'(rejectPulse), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single entry, button held 3 cycles
        expect_gate(1);
        press(1'b1, 1'b0, 3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("entry1_occ", int'(occupancy), 1);
        chk("entry1_empty", int'(empty), 0);

        // Fill the lot
        for (int i = 2; i <= CAP; i++) begin
            expect_gate(i);
            press(1'b1, 1'b0, 2);
            repeat (20) @(posedge clk);
        end
        @(negedge clk);
        chk("fill_occ", int'(occupancy), CAP);
        chk("fill_full", int'(full), 1);

        // Entry while full is refused
        expect_reject(CAP);
        press(1'b1, 1'b0, 2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("reject_occ", int'(occupancy), CAP);
        chk("reject_gate", int'(gateOpen), 0);

        // Drain to 3
        for (int i = CAP - 1; i >= 3; i--) begin
            expect_gate(i);
            press(1'b0, 1'b1, 2);
            repeat (20) @(posedge clk);
        end
        @(negedge clk);
        chk("drain_occ", int'(occupancy), 3);

        // Simultaneous entry and exit: exit wins, no reject
        expect_gate(2);
        press(1'b1, 1'b1, 2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("simul_occ", int'(occupancy), 2);

        // Second entry while gate open is discarded
        expect_gate(3);
        press(1'b1, 1'b0, 2);
        repeat (3) @(posedge clk);
        press(1'b1, 1'b0, 2);
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("open_ignore_occ", int'(occupancy), 3);

        // Empty the lot, then exit while empty
        for (int i = 2; i >= 0; i--) begin
            expect_gate(i);
            press(1'b0, 1'b1, 2);
            repeat (20) @(posedge clk);
        end
        press(1'b0, 1'b1, 2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("empty_exit_occ", int'(occupancy), 0);
        chk("empty_exit_gate", int'(gateOpen), 0);
        chk("empty_exit_empty", int'(empty), 1);

        // Reset in the middle of OPEN_IN with entryBtn held across release
        expect_gate(1);
        press(1'b1, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1 entryBtn = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_gate", int'(gateOpen), 0);
        chk("midrst_occ", int'(occupancy), 0);
        chk("midrst_empty", int'(empty), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 entryBtn = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("held_btn_occ", int'(occupancy), 0);
        chk("held_btn_gate", int'(gateOpen), 0);

        // Fresh edge after release is accepted
        expect_gate(1);
        press(1'b1, 1'b0, 2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("post_rst_occ", int'(occupancy), 1);

        // Every scheduled response must have appeared
        chk("pending_responses", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_parking_gate_ctrl
